// File: rtl/disp_pkg.sv
// Shared definitions for the display edit path: field codes, FSM states and
// field-cursor stepping helpers.
package disp_pkg;

    localparam int unsigned NFIELDS = 9;

    localparam logic [3:0] FIELD_FECHA  = 4'd0;
    localparam logic [3:0] FIELD_MES    = 4'd1;
    localparam logic [3:0] FIELD_ANIO   = 4'd2;
    localparam logic [3:0] FIELD_HORA   = 4'd3;
    localparam logic [3:0] FIELD_MIN    = 4'd4;
    localparam logic [3:0] FIELD_SEG    = 4'd5;
    localparam logic [3:0] FIELD_T_HORA = 4'd6;
    localparam logic [3:0] FIELD_T_MIN  = 4'd7;
    localparam logic [3:0] FIELD_T_SEG  = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EDIT,
        ST_WRITE
    } state_e;

    function automatic logic [3:0] field_next(input logic [3:0] f);
        return (f >= FIELD_T_SEG) ? FIELD_FECHA : f + 4'd1;
    endfunction

    function automatic logic [3:0] field_prev(input logic [3:0] f);
        return (f == FIELD_FECHA || f > FIELD_T_SEG) ? FIELD_T_SEG : f - 4'd1;
    endfunction

endpackage

// File: rtl/blink_timer.sv
// Free-running blink divider: toggles blink_o every BLINK_HALF cycles and
// strobes tog_o in the cycle whose clock edge performs the toggle.
module blink_timer #(
    parameter int unsigned BLINK_HALF = 50_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic blink_o,
    output logic tog_o
);

    localparam int unsigned CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [CW-1:0] TERM = CW'(BLINK_HALF - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          blink_q, blink_d;

    always_comb begin
        tog_o   = !clr_i && (cnt_q == TERM);
        cnt_d   = cnt_q + 1'b1;
        blink_d = blink_q;
        if (clr_i) begin
            cnt_d   = '0;
            blink_d = 1'b1;
        end else if (tog_o) begin
            cnt_d   = '0;
            blink_d = ~blink_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            blink_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            blink_q <= blink_d;
        end
    end

    assign blink_o = blink_q;

endmodule

// File: rtl/edit_cursor_ctrl.sv
// Edit-mode cursor controller: field selection, blink, inactivity timeout and
// handshaked increment/decrement requests towards the RTC register writer.
module edit_cursor_ctrl
    import disp_pkg::*;
#(
    parameter int unsigned BLINK_HALF      = 50_000_000,
    parameter int unsigned TIMEOUT_TOGGLES = 20
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       btn_edit_i,
    input  logic       btn_next_i,
    input  logic       btn_prev_i,
    input  logic       btn_up_i,
    input  logic       btn_down_i,
    input  logic       wr_ack_i,
    output logic [3:0] dir_o,
    output logic       cursor_o,
    output logic       blink_o,
    output logic       wr_req_o,
    output logic [3:0] wr_field_o,
    output logic       wr_delta_o,
    output logic       busy_o
);

    localparam int unsigned TW = $clog2(TIMEOUT_TOGGLES + 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_TOGGLES);

    state_e        state_q, state_d;
    logic [3:0]    dir_q, dir_d;
    logic [TW-1:0] to_q, to_d;
    logic [3:0]    field_q, field_d;
    logic          delta_q, delta_d;
    logic          blink_clr;
    logic          tog;
    logic          any_btn;

    blink_timer #(
        .BLINK_HALF(BLINK_HALF)
    ) u_blink (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (blink_clr),
        .blink_o(blink_o),
        .tog_o  (tog)
    );

    assign any_btn = btn_edit_i | btn_next_i | btn_prev_i | btn_up_i | btn_down_i;

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        to_d      = to_q;
        field_d   = field_q;
        delta_d   = delta_q;
        blink_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (btn_edit_i) begin
                    state_d   = ST_EDIT;
                    dir_d     = FIELD_FECHA;
                    to_d      = '0;
                    blink_clr = 1'b1;
                end
            end
            ST_EDIT: begin
                if (tog && (to_q != TO_MAX)) begin
                    to_d = to_q + 1'b1;
                end
                // A press restarts the inactivity window even if a toggle lands this cycle.
                if (any_btn) begin
                    to_d = '0;
                end
                if (btn_edit_i) begin
                    state_d = ST_IDLE;
                end else if (btn_up_i || btn_down_i) begin
                    state_d = ST_WRITE;
                    field_d = dir_q;
                    delta_d = btn_up_i;
                end else if (btn_next_i) begin
                    dir_d = field_next(dir_q);
                end else if (btn_prev_i) begin
                    dir_d = field_prev(dir_q);
                end else if (to_q == TO_MAX) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (wr_ack_i) begin
                    state_d = ST_EDIT;
                    to_d    = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            dir_q   <= FIELD_FECHA;
            to_q    <= '0;
            field_q <= 4'd0;
            delta_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            to_q    <= to_d;
            field_q <= field_d;
            delta_q <= delta_d;
        end
    end

    assign dir_o      = dir_q;
    assign cursor_o   = (state_q != ST_IDLE);
    assign wr_req_o   = (state_q == ST_WRITE);
    assign busy_o     = (state_q == ST_WRITE);
    assign wr_field_o = field_q;
    assign wr_delta_o = delta_q;

endmodule

// File: tb/tb_edit_cursor_ctrl.sv
// Directed self-checking bench for edit_cursor_ctrl with BLINK_HALF=4 and
// TIMEOUT_TOGGLES=3.
module tb_edit_cursor_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       btn_edit_i, btn_next_i, btn_prev_i, btn_up_i, btn_down_i;
    logic       wr_ack_i;
    logic [3:0] dir_o;
    logic       cursor_o, blink_o, wr_req_o, wr_delta_o, busy_o;
    logic [3:0] wr_field_o;

    int tests = 0;
    int fails = 0;

    edit_cursor_ctrl #(
        .BLINK_HALF     (4),
        .TIMEOUT_TOGGLES(3)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .btn_edit_i(btn_edit_i),
        .btn_next_i(btn_next_i),
        .btn_prev_i(btn_prev_i),
        .btn_up_i  (btn_up_i),
        .btn_down_i(btn_down_i),
        .wr_ack_i  (wr_ack_i),
        .dir_o     (dir_o),
        .cursor_o  (cursor_o),
        .blink_o   (blink_o),
        .wr_req_o  (wr_req_o),
        .wr_field_o(wr_field_o),
        .wr_delta_o(wr_delta_o),
        .busy_o    (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_next();
        btn_next_i = 1'b1;
        tick();
        btn_next_i = 1'b0;
    endtask

    task automatic pulse_prev();
        btn_prev_i = 1'b1;
        tick();
        btn_prev_i = 1'b0;
    endtask

    task automatic pulse_edit();
        btn_edit_i = 1'b1;
        tick();
        btn_edit_i = 1'b0;
    endtask

    initial begin
        rst_i      = 1'b1;
        btn_edit_i = 1'b0;
        btn_next_i = 1'b0;
        btn_prev_i = 1'b0;
        btn_up_i   = 1'b0;
        btn_down_i = 1'b0;
        wr_ack_i   = 1'b0;
        tick();
        tick();
        chk("rst_dir", 8'(dir_o), 8'd0);
        chk("rst_cursor", 8'(cursor_o), 8'd0);
        chk("rst_blink", 8'(blink_o), 8'd0);
        chk("rst_req", 8'(wr_req_o), 8'd0);
        chk("rst_field", 8'(wr_field_o), 8'd0);
        chk("rst_delta", 8'(wr_delta_o), 8'd0);
        chk("rst_busy", 8'(busy_o), 8'd0);
        rst_i = 1'b0;
        tick();

        // IDLE ignores everything except edit, including ack.
        btn_next_i = 1'b1;
        btn_up_i   = 1'b1;
        wr_ack_i   = 1'b1;
        tick();
        btn_next_i = 1'b0;
        btn_up_i   = 1'b0;
        wr_ack_i   = 1'b0;
        chk("idle_ign_cursor", 8'(cursor_o), 8'd0);
        chk("idle_ign_req", 8'(wr_req_o), 8'd0);
        chk("idle_ign_dir", 8'(dir_o), 8'd0);

        // Enter edit, then blink holds 1 for four cycles and drops.
        pulse_edit();
        chk("enter_cursor", 8'(cursor_o), 8'd1);
        chk("enter_dir", 8'(dir_o), 8'd0);
        chk("enter_blink", 8'(blink_o), 8'd1);
        tick();
        tick();
        tick();
        chk("blink_hold", 8'(blink_o), 8'd1);
        tick();
        chk("blink_toggle", 8'(blink_o), 8'd0);

        // Field wrap both ways.
        pulse_prev();
        chk("prev_wrap", 8'(dir_o), 8'd8);
        for (int i = 0; i < 9; i++) begin
            pulse_next();
            chk("next_step", 8'(dir_o), 8'(i));
        end
        for (int i = 0; i < 4; i++) pulse_prev();
        chk("prev_to4", 8'(dir_o), 8'd4);

        // Write handshake with stalled ack.
        btn_up_i = 1'b1;
        tick();
        btn_up_i = 1'b0;
        chk("up_req", 8'(wr_req_o), 8'd1);
        chk("up_field", 8'(wr_field_o), 8'd4);
        chk("up_delta", 8'(wr_delta_o), 8'd1);
        chk("up_busy", 8'(busy_o), 8'd1);
        chk("up_cursor", 8'(cursor_o), 8'd1);
        for (int i = 0; i < 5; i++) begin
            pulse_next();
            chk("stall_req", 8'(wr_req_o), 8'd1);
            chk("stall_dir", 8'(dir_o), 8'd4);
        end
        wr_ack_i = 1'b1;
        tick();
        wr_ack_i = 1'b0;
        chk("ack_req", 8'(wr_req_o), 8'd0);
        chk("ack_busy", 8'(busy_o), 8'd0);
        chk("ack_cursor", 8'(cursor_o), 8'd1);

        // Minimum-width request: ack already high (ignored in EDIT) when down lands.
        btn_down_i = 1'b1;
        wr_ack_i   = 1'b1;
        tick();
        btn_down_i = 1'b0;
        chk("down_req", 8'(wr_req_o), 8'd1);
        chk("down_delta", 8'(wr_delta_o), 8'd0);
        chk("down_field", 8'(wr_field_o), 8'd4);
        tick();
        wr_ack_i = 1'b0;
        chk("min_req", 8'(wr_req_o), 8'd0);
        chk("min_cursor", 8'(cursor_o), 8'd1);

        // Timeout: toggles at E+4, E+8, E+12, exit at E+13.
        pulse_edit();
        chk("exit_cursor", 8'(cursor_o), 8'd0);
        pulse_edit();
        for (int i = 0; i < 12; i++) tick();
        chk("to_before", 8'(cursor_o), 8'd1);
        tick();
        chk("to_exit", 8'(cursor_o), 8'd0);

        // Timeout restart by a press coinciding with toggle 2.
        pulse_edit();
        for (int i = 0; i < 7; i++) tick();
        pulse_next();
        chk("restart_dir", 8'(dir_o), 8'd1);
        for (int i = 0; i < 12; i++) tick();
        chk("restart_before", 8'(cursor_o), 8'd1);
        tick();
        chk("restart_exit", 8'(cursor_o), 8'd0);

        // Priority: edit beats up.
        pulse_edit();
        btn_edit_i = 1'b1;
        btn_up_i   = 1'b1;
        tick();
        btn_edit_i = 1'b0;
        btn_up_i   = 1'b0;
        chk("prio_cursor", 8'(cursor_o), 8'd0);
        chk("prio_req", 8'(wr_req_o), 8'd0);
        tick();
        chk("prio_req_later", 8'(wr_req_o), 8'd0);
        chk("prio_busy", 8'(busy_o), 8'd0);

        // Asynchronous reset in WRITE.
        pulse_edit();
        pulse_next();
        btn_up_i = 1'b1;
        tick();
        btn_up_i = 1'b0;
        chk("pre_rst_req", 8'(wr_req_o), 8'd1);
        chk("pre_rst_dir", 8'(dir_o), 8'd1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("arst_req", 8'(wr_req_o), 8'd0);
        chk("arst_cursor", 8'(cursor_o), 8'd0);
        chk("arst_busy", 8'(busy_o), 8'd0);
        chk("arst_dir", 8'(dir_o), 8'd0);
        tick();
        rst_i = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/edit_cursor_ctrl.md
# edit_cursor_ctrl

Edit-mode controller for the clock/date/timer display. Takes debounced button pulses and sequences the on-screen edit cursor: which of the 9 numeric fields is selected, whether the cursor is shown, and the blink phase. It also issues handshaked increment/decrement requests for the selected field to the RTC register writer. Its outputs drive the text generator's `dir`, `cursor` and blink inputs directly.

## Interface
- `BLINK_HALF`, 50_000_000 — clk_i cycles per blink half-period (1 Hz blink at 100 MHz).
- `TIMEOUT_TOGGLES`, 20 — blink toggles without a button press before EDIT auto-exits (10 s at default).

- `clk_i`  in  1  system clock; single clock domain.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `btn_edit_i`, `btn_next_i`, `btn_prev_i`, `btn_up_i`, `btn_down_i`  in  1 each  single-cycle debounced pulses.
- `wr_ack_i`  in  1  writer accepted the request.
- `dir_o`  out  4  selected field: 0 day, 1 month, 2 year, 3 clock hour, 4 clock min, 5 clock sec, 6 timer hour, 7 timer min, 8 timer sec.
- `cursor_o`  out  1  high in EDIT and WRITE.
- `blink_o`  out  1  cursor blink phase.
- `wr_req_o`  out  1  increment/decrement request.
- `wr_field_o`  out  4  field to modify; stable while `wr_req_o` is high.
- `wr_delta_o`  out  1  1 = +1, 0 = −1.
- `busy_o`  out  1  high in WRITE.

## Operation
- FSM states: IDLE, EDIT, WRITE.
- IDLE:
  - `btn_edit_i` → EDIT; `dir_o` ← 0; blink counter ← 0; `blink_o` ← 1; timeout ← 0.
  - All other buttons are ignored.
- EDIT: one action per cycle, priority edit > up > down > next > prev. Lower-priority pulses in the same cycle are dropped.
  - edit → IDLE.
  - up/down → WRITE. Latch `wr_field_o` = `dir_o` and `wr_delta_o` = up.
  - next: `dir_o` +1, wrapping 8 → 0.
  - prev: `dir_o` −1, wrapping 0 → 8.
  - Any button pulse clears the timeout counter.
  - Timeout counter reaches `TIMEOUT_TOGGLES` → IDLE.
- WRITE:
  - `wr_req_o` is held high until `wr_ack_i` is sampled high, then → EDIT with timeout cleared.
  - Buttons are dropped. The timeout counter is frozen.
- `wr_ack_i` outside WRITE is ignored.
- Blink counter:
  - Counts 0..`BLINK_HALF`−1 and toggles `blink_o` at the terminal count.
  - Runs in all states.
  - In EDIT, each toggle increments the timeout counter, which saturates at `TIMEOUT_TOGGLES`.
- Widths:
  - Blink counter is $clog2(`BLINK_HALF`) bits.
  - Timeout counter is $clog2(`TIMEOUT_TOGGLES`+1) bits.
  - `dir_o` never holds 9–15.

## Timing
- Reset values: state IDLE; `dir_o` 0; `cursor_o`, `blink_o`, `wr_req_o`, `wr_field_o`, `wr_delta_o`, `busy_o` all 0; counters 0.
- All outputs are registered. A button sampled at edge N is reflected in the outputs after edge N, with 1-cycle latency.
- `wr_req_o` and `busy_o` rise after the edge that samples up/down.
- Ack sampled at edge M clears `wr_req_o` after edge M. The minimum request width is 1 cycle (ack already high at the first edge of the request).
- `cursor_o` is derived from the registered state, with no extra delay.
- Asynchronous reset mid-WRITE drops `wr_req_o` immediately. The writer must tolerate an abandoned request.

## Structure
- Shared package `disp_pkg`:
  - field codes `FIELD_FECHA`..`FIELD_T_SEG` (0..8);
  - `NFIELDS` = 9;
  - state enum `{ST_IDLE, ST_EDIT, ST_WRITE}`.
- Sub-module `blink_timer`:
  - parameter `BLINK_HALF`;
  - inputs `clk_i`, `rst_i`, `clr_i`;
  - outputs `blink_o`, `tog_o` (1-cycle strobe per toggle).
  - `clr_i` forces the count to 0 and `blink_o` to 1.

## Test plan
Use `BLINK_HALF`=4 and `TIMEOUT_TOGGLES`=3.
- **Enter edit:** reset, then `btn_edit_i` pulse → next cycle `cursor_o`=1, `dir_o`=0, `blink_o`=1; `blink_o` toggles every 4 cycles after that.
- **Field wrap:** `btn_prev_i` at `dir_o`=0 → `dir_o`=8. Then nine `btn_next_i` pulses → `dir_o` steps 0,1,…,8.
- **Write handshake:** `btn_up_i` at `dir_o`=4 → `wr_req_o`=1, `wr_field_o`=4, `wr_delta_o`=1, `busy_o`=1.
  - Hold `wr_ack_i`=0 for 5 cycles with `btn_next_i` pulses → `wr_req_o` stays 1 and `dir_o` stays 4.
  - `wr_ack_i`=1 → next cycle `wr_req_o`=0, `busy_o`=0, `cursor_o`=1.
- **Timeout:** in EDIT with no buttons, after 3 blink toggles (≈12 cycles) → `cursor_o`=0.
  - A `btn_next_i` pulse at toggle 2 restarts the count, so exit comes 3 toggles after that pulse.
- **Priority:** `btn_edit_i` and `btn_up_i` in the same cycle in EDIT → IDLE, and `wr_req_o` never rises.
- **Reset mid-write:** assert `rst_i` during WRITE → `wr_req_o`, `cursor_o`, `busy_o` go 0 asynchronously, and `dir_o`=0.
